flop_share_arbiter: RTL and testbench

FLOP_SHARE_ARBITER -- requirements
Module: flop_share_arbiter

---
 rtl/flop_share_arbiter.sv | 103 ++++++++++
 tb/tb_flop_share_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/flop_share_arbiter.sv
// flop_share_arbiter: round-robin arbiter that lends a shared register to one requester for HOLD cycles
module flop_share_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int HOLD  = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   wdata,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] owner,
   output logic                    busy,
   output logic                    done,
   output logic [WIDTH-1:0]        q,
   output logic [WIDTH-1:0]        qb
);
   localparam int OW = $clog2(NREQ);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t            st_q, st_d;
   logic [OW-1:0]     owner_q, owner_d, ptr_q, ptr_d, win, nxt;
   logic [3:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]  q_q, q_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [2*NREQ-1:0] dbl;
   logic              busy_q, busy_d, done_q, done_d, own_req, last;
   int                off, sum;

   assign own_req = req[owner_q];
   assign last    = cnt_q == 4'd0;
   assign nxt     = owner_q == OW'(NREQ-1) ? '0 : owner_q + OW'(1);
   assign dbl     = {req, req} >> ptr_q;

   // round-robin search: the smallest offset from ptr with a pending request wins
   always_comb begin
      off = 0;
      for (int k = NREQ-1; k >= 0; k--)
         if (dbl[k]) off = k;
      sum = int'(ptr_q) + off;
      win = OW'(sum >= NREQ ? sum - NREQ : sum);
   end

   // next state: arbitrate in IDLE, load and count down in GRANT, leave on completion or abort
   always_comb begin
      st_d    = st_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      if (st_q == IDLE) begin
         if (|req) begin
            st_d    = GRANT;
            owner_d = win;
            cnt_d   = 4'(HOLD-1);
         end
      end else if (own_req) begin
         q_d   = wdata[int'(owner_q)*WIDTH +: WIDTH];
         cnt_d = last ? cnt_q : cnt_q - 4'd1;
         st_d  = last ? IDLE : GRANT;
         ptr_d = last ? nxt : ptr_q;
      end else begin
         st_d  = IDLE;
         ptr_d = nxt;
      end
   end

   // registered outputs follow the state being entered; done marks only full-length grants
   always_comb begin
      gnt_d  = st_d == GRANT ? NREQ'(1) << owner_d : '0;
      busy_d = st_d == GRANT;
      done_d = st_q == GRANT && own_req && last;
   end

   // state and output registers, cleared immediately by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q    <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         gnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         st_q    <= st_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         gnt_q   <= gnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign gnt   = gnt_q;
   assign owner = owner_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign q     = q_q;
   assign qb    = ~q_q;
endmodule

// File: tb/tb_flop_share_arbiter.sv
// tb_flop_share_arbiter: randomized and directed checks against a grant-level reference model
module tb_flop_share_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int HOLD  = 2;

   logic                  clk, reset;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       gnt;
   logic [1:0]            owner;
   logic                  busy, done;
   logic [WIDTH-1:0]      q, qb;

   flop_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(HOLD)) dut (
      .clk(clk), .reset(reset), .req(req), .wdata(wdata),
      .gnt(gnt), .owner(owner), .busy(busy), .done(done), .q(q), .qb(qb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   bit               m_busy, m_done;
   int               m_owner, m_ptr, m_left, run;
   logic [WIDTH-1:0] m_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_done = 0; m_owner = 0; m_ptr = 0; m_left = 0; m_q = '0; run = 0;
   endtask

   // one clock edge of the arbiter, described as grants with a number of loads left
   task automatic model_step();
      logic [NREQ-1:0]       r;
      logic [NREQ*WIDTH-1:0] s;
      bit                    found;
      m_done = 0;
      if (!m_busy) begin
         found = 0;
         for (int k = 0; k < NREQ; k++) begin
            r = req >> ((m_ptr + k) % NREQ);
            if (!found && r[0]) begin
               found   = 1;
               m_owner = (m_ptr + k) % NREQ;
            end
         end
         if (found) begin
            m_busy = 1;
            m_left = HOLD;
         end
      end else begin
         r = req >> m_owner;
         if (r[0]) begin
            s      = wdata >> (m_owner * WIDTH);
            m_q    = s[WIDTH-1:0];
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_busy = 0;
               m_done = 1;
               m_ptr  = (m_owner + 1) % NREQ;
            end
         end else begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % NREQ;
         end
      end
   endtask

   task automatic compare();
      logic [WIDTH-1:0] nq;
      nq = ~m_q;
      check("gnt", gnt, m_busy ? (1 << m_owner) : 0);
      check("owner", owner, m_owner);
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("q", q, m_q);
      check("qb", qb, nq);
      check("onehot0", $onehot0(gnt), 1);
      if (done) check("done_len", run, HOLD);
      run = (gnt != 0) ? run + 1 : 0;
   endtask

   task automatic cyc(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d);
      req   = r;
      wdata = d;
      @(posedge clk);
      model_step();
      #1 compare();
      @(negedge clk);
   endtask

   // reset asserted between edges, checked before any edge, released on a falling edge
   task automatic rst_pulse();
      #2 reset = 1'b0;
      model_reset();
      #1;
      check("rst_gnt", gnt, 0);
      check("rst_busy", busy, 0);
      check("rst_q", q, 8'h00);
      check("rst_qb", qb, 8'hFF);
      compare();
      @(negedge clk);
      reset = 1'b1;
   endtask

   logic [NREQ*WIDTH-1:0] d;
   logic [WIDTH-1:0]      qsave;

   initial begin
      reset = 1'b1;
      req   = '0;
      wdata = '0;
      model_reset();
      @(negedge clk);
      rst_pulse();

      d = $urandom;
      d[2*WIDTH +: WIDTH] = 8'hA5;
      cyc(4'b0100, d);
      check("s_gnt", gnt, 4'b0100);
      check("s_owner", owner, 2);
      cyc(4'b0100, d);
      check("s_q", q, 8'hA5);
      check("s_gnt2", gnt, 4'b0100);
      cyc(4'b0100, d);
      check("s_done", done, 1);
      check("s_gnt3", gnt, 0);

      cyc(4'b0011, $urandom);
      check("w_owner0", owner, 0);
      cyc(4'b0011, $urandom);
      cyc(4'b0011, $urandom);
      cyc(4'b0011, $urandom);
      check("w_owner1", owner, 1);
      cyc(4'b0011, $urandom);
      cyc(4'b0011, $urandom);

      cyc(4'b0001, $urandom);
      check("m_busy", busy, 1);
      rst_pulse();

      for (int g = 0; g < 5; g++) begin
         cyc(4'b1111, $urandom);
         check("rr_gnt", gnt, 1 << (g % 4));
         cyc(4'b1111, $urandom);
         cyc(4'b1111, $urandom);
         check("rr_done", done, 1);
      end

      qsave = m_q;
      cyc(4'b0010, $urandom);
      check("a_owner", owner, 1);
      cyc(4'b0000, $urandom);
      check("a_busy", busy, 0);
      check("a_done", done, 0);
      check("a_q", q, qsave);
      cyc(4'b1111, $urandom);
      check("a_ptr", owner, 2);
      cyc(4'b1111, $urandom);
      cyc(4'b1111, $urandom);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 149) == 0) rst_pulse();
         if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
         cyc(req, $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
